stream_argmin: RTL

STREAM_ARGMIN -- requirements
Module: stream_argmin

---
 rtl/stream_argmin.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/stream_argmin.sv
`default_nettype none
// ============================================================================
// Module   : stream_argmin
// Purpose  : Streaming argmin over framed groups of up to N values.
// Revision : 1.0  initial release
// ============================================================================
module stream_argmin #(
    parameter int W      = 64,
    parameter int N      = 10,
    parameter int IDX_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_value,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [W-1:0]     out_value,
    output logic [IDX_W-1:0] out_count,
    output logic             out_trunc
);
    localparam logic [IDX_W-1:0] c_max_beats = IDX_W'(N);
    localparam logic [IDX_W-1:0] c_one       = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_run;
    logic [W-1:0]     r_min, w_min_nxt;
    logic [IDX_W-1:0] r_min_idx, w_min_idx_nxt;
    logic [IDX_W-1:0] r_count, w_count_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [IDX_W-1:0] r_out_index, w_out_index_nxt;
    logic [W-1:0]     r_out_value, w_out_value_nxt;
    logic [IDX_W-1:0] r_out_count, w_out_count_nxt;
    logic             r_out_trunc, w_out_trunc_nxt;

    logic             w_accept;
    logic             w_start;
    logic             w_less;
    logic [IDX_W-1:0] w_count_inc;
    logic [W-1:0]     w_cand_value;
    logic [IDX_W-1:0] w_cand_idx;

    // r_run holds in_ready low until the first edge after reset release.
    assign in_ready     = r_run && ((r_state != ST_DONE) || out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_start      = w_accept && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_count_inc  = r_count + c_one;
    assign w_cand_value = w_less ? in_value : r_min;
    assign w_cand_idx   = w_less ? r_count : r_min_idx;

    generate
        if (SIGNED != 0) begin : g_signed_cmp
            assign w_less = $signed(in_value) < $signed(r_min);
        end else begin : g_unsigned_cmp
            assign w_less = in_value < r_min;
        end
    endgenerate

    always_comb begin
        w_state_nxt     = r_state;
        w_min_nxt       = r_min;
        w_min_idx_nxt   = r_min_idx;
        w_count_nxt     = r_count;
        w_out_index_nxt = r_out_index;
        w_out_value_nxt = r_out_value;
        w_out_count_nxt = r_out_count;
        w_out_trunc_nxt = r_out_trunc;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    w_min_nxt     = w_cand_value;
                    w_min_idx_nxt = w_cand_idx;
                    w_count_nxt   = w_count_inc;
                    if (in_last || (w_count_inc == c_max_beats)) begin
                        w_state_nxt     = ST_DONE;
                        w_out_index_nxt = w_cand_idx;
                        w_out_value_nxt = w_cand_value;
                        w_out_count_nxt = w_count_inc;
                        w_out_trunc_nxt = !in_last;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A beat taken in IDLE, or while DONE drains, opens a fresh group.
        if (w_start) begin
            w_min_nxt     = in_value;
            w_min_idx_nxt = '0;
            w_count_nxt   = c_one;
            if (in_last) begin
                w_state_nxt     = ST_DONE;
                w_out_index_nxt = '0;
                w_out_value_nxt = in_value;
                w_out_count_nxt = c_one;
                w_out_trunc_nxt = 1'b0;
            end else begin
                w_state_nxt = ST_ACCUM;
            end
        end

        w_out_valid_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_run       <= 1'b0;
            r_min       <= '0;
            r_min_idx   <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_value <= '0;
            r_out_count <= '0;
            r_out_trunc <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= 1'b1;
            r_min       <= w_min_nxt;
            r_min_idx   <= w_min_idx_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_index <= w_out_index_nxt;
            r_out_value <= w_out_value_nxt;
            r_out_count <= w_out_count_nxt;
            r_out_trunc <= w_out_trunc_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_value = r_out_value;
    assign out_count = r_out_count;
    assign out_trunc = r_out_trunc;

endmodule
`default_nettype wire
